// File: rtl/atm_cash_dispenser.sv
// Cash dispenser: plans a greedy note mix against cassette stock, then releases
// notes one at a time with a fixed mechanical gap and reports done or fail.
module atm_cash_dispenser #(
  parameter int AMT_W    = 11,
  parameter int CNT_W    = 8,
  parameter int D2       = 100,
  parameter int D1       = 50,
  parameter int D0       = 10,
  parameter int INIT_CNT = 100,
  parameter int NOTE_GAP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             reload_i,
  output logic             ready_o,
  output logic             note_out_o,
  output logic [1:0]       note_sel_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [1:0]       fail_code_o,
  output logic [CNT_W-1:0] stock2_o,
  output logic [CNT_W-1:0] stock1_o,
  output logic [CNT_W-1:0] stock0_o
);

  localparam logic [AMT_W-1:0] D2_A     = AMT_W'(D2);
  localparam logic [AMT_W-1:0] D1_A     = AMT_W'(D1);
  localparam logic [AMT_W-1:0] D0_A     = AMT_W'(D0);
  localparam logic [CNT_W-1:0] INIT_S   = CNT_W'(INIT_CNT);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam int               GAP_W    = (NOTE_GAP > 2) ? $clog2(NOTE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((NOTE_GAP > 1) ? NOTE_GAP - 2 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W+1:0] ONE_LEFT = (CNT_W+2)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_FAIL, S_DISP, S_GAP, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [CNT_W-1:0] stock_w [3];
  logic [CNT_W-1:0] cnt_w   [3];
  logic [CNT_W-1:0] plan_w  [3];

  logic [AMT_W-1:0] q2, n2, r1, q1, n1, r2, q0, n0, r3;
  logic [1:0]       plan_code, sel_idx;
  logic [CNT_W+1:0] left_sum;
  logic             idle, accept, load_stock, plan_ok, in_disp;

  assign idle       = (state_q == S_IDLE);
  assign load_stock = idle && reload_i;
  assign accept     = idle && !reload_i && req_i;
  assign in_disp    = (state_q == S_DISP);

  // Greedy mix, each denomination capped by what its cassette holds.
  always_comb begin
    q2 = amt_q / D2_A;
    n2 = (q2 < AMT_W'(stock_w[2])) ? q2 : AMT_W'(stock_w[2]);
    r1 = amt_q - n2 * D2_A;
    q1 = r1 / D1_A;
    n1 = (q1 < AMT_W'(stock_w[1])) ? q1 : AMT_W'(stock_w[1]);
    r2 = r1 - n1 * D1_A;
    q0 = r2 / D0_A;
    n0 = (q0 < AMT_W'(stock_w[0])) ? q0 : AMT_W'(stock_w[0]);
    r3 = r2 - n0 * D0_A;
    plan_w[2] = n2[CNT_W-1:0];
    plan_w[1] = n1[CNT_W-1:0];
    plan_w[0] = n0[CNT_W-1:0];
    if (amt_q == '0)                 plan_code = 2'b01;
    else if ((amt_q % D0_A) != '0)   plan_code = 2'b10;
    else if (r3 != '0)               plan_code = 2'b11;
    else                             plan_code = 2'b00;
  end

  assign plan_ok  = (state_q == S_PLAN) && (plan_code == 2'b00);
  assign sel_idx  = (cnt_w[2] != '0) ? 2'd2 : ((cnt_w[1] != '0) ? 2'd1 : 2'd0);
  assign left_sum = {2'b00, cnt_w[2]} + {2'b00, cnt_w[1]} + {2'b00, cnt_w[0]};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cas
      logic [CNT_W-1:0] stock_q, stock_d, cnt_q, cnt_d;
      logic             dec;

      assign dec = in_disp && (sel_idx == 2'(gi));

      always_comb begin
        stock_d = stock_q;
        cnt_d   = cnt_q;
        if (load_stock) begin
          stock_d = INIT_S;
        end else if (dec) begin
          stock_d = stock_q - ONE_C;
          cnt_d   = cnt_q - ONE_C;
        end
        if (plan_ok) cnt_d = plan_w[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stock_q <= INIT_S;
          cnt_q   <= '0;
        end else begin
          stock_q <= stock_d;
          cnt_q   <= cnt_d;
        end
      end

      assign stock_w[gi] = stock_q;
      assign cnt_w[gi]   = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_PLAN;
      S_PLAN: state_d = (plan_code != 2'b00) ? S_FAIL : S_DISP;
      S_FAIL: state_d = S_IDLE;
      S_DISP: begin
        if (NOTE_GAP > 1)            state_d = S_GAP;
        else if (left_sum > ONE_LEFT) state_d = S_DISP;
        else                          state_d = S_FIN;
      end
      S_GAP: if (gap_q == GAP_LAST) state_d = (left_sum != '0) ? S_DISP : S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o    = idle;
    note_out_o = in_disp;
    note_sel_o = in_disp ? sel_idx : 2'd0;
    done_o     = (state_q == S_FIN);
    fail_o     = (state_q == S_FAIL);
  end

  always_comb begin
    amt_d       = amt_q;
    fail_code_d = fail_code_q;
    gap_d       = gap_q;
    if (accept) begin
      amt_d       = amount_i;
      fail_code_d = 2'b00;
    end
    if (state_q == S_PLAN) fail_code_d = plan_code;
    if (in_disp) gap_d = '0;
    else if (state_q == S_GAP) gap_d = gap_q + GAP_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amt_q       <= '0;
      fail_code_q <= 2'b00;
      gap_q       <= '0;
    end else begin
      amt_q       <= amt_d;
      fail_code_q <= fail_code_d;
      gap_q       <= gap_d;
    end
  end

  assign fail_code_o = fail_code_q;
  assign stock2_o    = stock_w[2];
  assign stock1_o    = stock_w[1];
  assign stock0_o    = stock_w[0];

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Scoreboard bench: stimulus pushes hand-computed note/done/fail events with
// their expected cycle; a monitor pops and compares whenever the DUT emits one.
module tb_atm_cash_dispenser;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        reload = 1'b0;
  logic [10:0] amount = '0;
  logic        ready, note_out, done, fail;
  logic [1:0]  note_sel, fail_code;
  logic [7:0]  stock2, stock1, stock0;

  atm_cash_dispenser dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .amount_i(amount), .reload_i(reload),
    .ready_o(ready), .note_out_o(note_out), .note_sel_o(note_sel), .done_o(done),
    .fail_o(fail), .fail_code_o(fail_code),
    .stock2_o(stock2), .stock1_o(stock1), .stock0_o(stock0)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind is {note, done, fail}
  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  sel;
    logic [1:0]  code;
    logic [31:0] cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_obs, mon_exp;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (note_out || done || fail)) begin
      mon_obs.kind = {note_out, done, fail};
      mon_obs.sel  = note_sel;
      mon_obs.code = fail_code;
      mon_obs.cyc  = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual kind=%b sel=%0d code=%0d cyc=%0d required none",
                 mon_obs.kind, mon_obs.sel, mon_obs.code, mon_obs.cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL event actual kind=%b sel=%0d code=%0d cyc=%0d required kind=%b sel=%0d code=%0d cyc=%0d",
                   mon_obs.kind, mon_obs.sel, mon_obs.code, mon_obs.cyc,
                   mon_exp.kind, mon_exp.sel, mon_exp.code, mon_exp.cyc);
        end
      end
    end
  end

  task automatic push_ev(input logic [2:0] kind, input logic [1:0] sel,
                         input logic [1:0] code, input logic [31:0] c);
    ev_t e;
    e.kind = kind; e.sel = sel; e.code = code; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Drives one accepted request; e2/e1/e0 are the hand-computed note counts.
  task automatic start_req(input logic [10:0] amt, input int e2, input int e1,
                           input int e0, input logic [1:0] fcode);
    logic [31:0] base, t;
    @(negedge clk);
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1;
    amount = amt;
    base = cyc;
    t = base + 2;
    if (fcode != 2'b00) begin
      push_ev(3'b001, 2'd0, fcode, t);
    end else begin
      for (int i = 0; i < e2; i++) begin push_ev(3'b100, 2'd2, 2'd0, t); t = t + GAP; end
      for (int i = 0; i < e1; i++) begin push_ev(3'b100, 2'd1, 2'd0, t); t = t + GAP; end
      for (int i = 0; i < e0; i++) begin push_ev(3'b100, 2'd0, 2'd0, t); t = t + GAP; end
      push_ev(3'b010, 2'd0, 2'd0, t);
    end
    $display("TXN cyc=%0d amount=%0d expect n2=%0d n1=%0d n0=%0d code=%0d",
             base, amt, e2, e1, e0, fcode);
    @(negedge clk);
    req = 1'b0;
    chk("ready_busy", {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, exp_q.size(), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [10:0] amt, input int e2,
                     input int e1, input int e0, input logic [1:0] fcode);
    start_req(amt, e2, e1, e0, fcode);
    wait_idle(name);
  endtask

  task automatic chk_stocks(input string name, input int s2, input int s1, input int s0);
    chk({name, "_stock2"}, {24'd0, stock2}, s2);
    chk({name, "_stock1"}, {24'd0, stock1}, s1);
    chk({name, "_stock0"}, {24'd0, stock0}, s0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    $display("TXN cyc=%0d reload", cyc);
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_note_out", {31'd0, note_out}, 32'd0);
    chk("rst_done_fail", {30'd0, done, fail}, 32'd0);
    chk("rst_fail_code", {30'd0, fail_code}, 32'd0);
    chk_stocks("rst", 100, 100, 100);
    rst_n = 1'b1;

    run("amt100", 11'd100, 1, 0, 0, 2'b00);
    chk_stocks("amt100", 99, 100, 100);

    do_reload();
    chk_stocks("reload1", 100, 100, 100);
    run("amt180", 11'd180, 1, 1, 3, 2'b00);
    chk_stocks("amt180", 99, 99, 97);

    run("amt0", 11'd0, 0, 0, 0, 2'b01);
    chk("amt0_code_held", {30'd0, fail_code}, 32'd1);
    chk_stocks("amt0", 99, 99, 97);
    run("amt55", 11'd55, 0, 0, 0, 2'b10);
    chk("amt55_code_held", {30'd0, fail_code}, 32'd2);
    chk_stocks("amt55", 99, 99, 97);

    do_reload();
    for (int i = 0; i < 100; i++) run("drain50", 11'd50, 0, 1, 0, 2'b00);
    chk_stocks("drain_mid", 100, 0, 100);
    for (int i = 0; i < 10; i++) run("drain90", 11'd90, 0, 0, 9, 2'b00);
    run("drain80", 11'd80, 0, 0, 8, 2'b00);
    chk_stocks("drained", 100, 0, 2);
    run("short50", 11'd50, 0, 0, 0, 2'b11);
    chk_stocks("short50", 100, 0, 2);

    do_reload();
    chk_stocks("reload2", 100, 100, 100);
    run("amt50", 11'd50, 0, 1, 0, 2'b00);
    chk_stocks("amt50", 100, 99, 100);

    @(negedge clk);
    req = 1'b1; reload = 1'b1; amount = 11'd100;
    $display("TXN cyc=%0d req+reload amount=100", cyc);
    @(negedge clk);
    req = 1'b0; reload = 1'b0;
    repeat (10) @(negedge clk);
    chk("both_ready", {31'd0, ready}, 32'd1);
    chk_stocks("both", 100, 100, 100);

    start_req(11'd100, 1, 0, 0, 2'b00);
    repeat (4) begin
      @(negedge clk);
      req = 1'b1; amount = 11'd50;
    end
    @(negedge clk);
    req = 1'b0;
    wait_idle("ignored_req");
    repeat (3) @(negedge clk);
    chk_stocks("ignored_req", 99, 100, 100);

    start_req(11'd180, 1, 1, 3, 2'b00);
    t = 0;
    while (exp_q.size() > 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_progress", exp_q.size(), 32'd4);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    $display("TXN cyc=%0d reset mid-payout", cyc);
    repeat (2) @(negedge clk);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk_stocks("midrst", 100, 100, 100);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_after_ready", {31'd0, ready}, 32'd1);
    chk_stocks("midrst_after", 100, 100, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
